// File: rtl/sqrt_feeder.sv
// sqrt_feeder: operand FIFO and sequencer for the iterative 8-bit root unit.
// Optional result checker enabled by defining SQRT_FEEDER_CHECK_EN (adds out_err).
module sqrt_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] sq_A,
    output logic       sq_start,
    input  logic       sq_ack,
    input  logic [3:0] sq_I,
    output logic       out_valid,
    output logic [7:0] out_operand,
    output logic [3:0] out_root,
    input  logic       out_ready,
    output logic       busy,
`ifdef SQRT_FEEDER_CHECK_EN
    output logic       err_timeout,
    output logic       out_err
`else
    output logic       err_timeout
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_LO, WAIT_HI, OUT, GAP
    } state_t;

    state_t state_q, state_d;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    sq_a_q, sq_a_d;
    logic [7:0]    opnd_q, opnd_d;
    logic [3:0]    root_q, root_d;
    logic [7:0]    tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          push, pop;

    assign in_ready = (count_q < FULL_CNT);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE) && (count_q != '0);

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; written only on an accepted push
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Sequencer next-state: issue, wait for ack low/high, present, cool down
    always_comb begin
        state_d = state_q;
        sq_a_d  = sq_a_q;
        opnd_d  = opnd_q;
        root_d  = root_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    sq_a_d  = mem_q[rd_ptr_q];
                    opnd_d  = mem_q[rd_ptr_q];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (tmo_q == TMO) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (!sq_ack) state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tmo_q == TMO) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (sq_ack) begin
                        root_d  = sq_I;
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (out_ready) state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer and FIFO registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sq_a_q   <= '0;
            opnd_q   <= '0;
            root_q   <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sq_a_q   <= sq_a_d;
            opnd_q   <= opnd_d;
            root_q   <= root_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    assign sq_A        = sq_a_q;
    assign sq_start    = (state_q == ISSUE);
    assign out_valid   = (state_q == OUT);
    assign out_operand = opnd_q;
    assign out_root    = root_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;

`ifdef SQRT_FEEDER_CHECK_EN
    logic [8:0] r9, rp1, a9, lo_sq, hi_sq;

    // Flag a root that does not bracket its operand; 9 bits hold 16*16
    always_comb begin
        r9      = {5'd0, root_q};
        rp1     = r9 + 9'd1;
        a9      = {1'b0, opnd_q};
        lo_sq   = r9 * r9;
        hi_sq   = rp1 * rp1;
        out_err = (state_q == OUT) && !((lo_sq <= a9) && (a9 < hi_sq));
    end
`endif

endmodule

// File: tb/tb_sqrt_feeder.sv
// tb_sqrt_feeder: scoreboard bench for sqrt_feeder with a behavioural root unit.
// Build with SQRT_FEEDER_CHECK_EN defined to also exercise out_err.
module tb_sqrt_feeder;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 63;
`ifdef SQRT_FEEDER_CHECK_EN
    localparam bit ERR_W = 1'b1;
`else
    localparam bit ERR_W = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic [7:0] sq_A;
    logic       sq_start;
    logic       sq_ack;
    logic [3:0] sq_I;
    logic       out_valid;
    logic [7:0] out_operand;
    logic [3:0] out_root;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       err_timeout;
    logic       err_bit;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 4;
    bit stall = 1'b0;
    bit wrong = 1'b0;
    int last_push = 0;
    int m_cnt = 0;
    logic [7:0] m_a;

    logic [12:0] exp_q[$];
    logic [12:0] got_q[$];
    int          start_q[$];

    sqrt_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .sq_A(sq_A), .sq_start(sq_start), .sq_ack(sq_ack), .sq_I(sq_I),
        .out_valid(out_valid), .out_operand(out_operand),
        .out_root(out_root), .out_ready(out_ready),
        .busy(busy),
`ifdef SQRT_FEEDER_CHECK_EN
        .err_timeout(err_timeout),
        .out_err(err_bit)
`else
        .err_timeout(err_timeout)
`endif
    );

`ifndef SQRT_FEEDER_CHECK_EN
    assign err_bit = 1'b0;
`endif

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [3:0] isqrt(input logic [7:0] a);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(a)) r++;
        return 4'(r);
    endfunction

    // Root unit model: ack drops on an accepted start, rises after lat cycles
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sq_ack <= 1'b1;
            sq_I   <= '0;
            m_cnt  <= 0;
            m_a    <= '0;
        end else if (sq_start) begin
            sq_ack <= 1'b0;
            m_cnt  <= lat;
            m_a    <= sq_A;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !stall) begin
                sq_ack <= 1'b1;
                sq_I   <= wrong ? 4'd8 : isqrt(m_a);
            end
        end
    end

    always @(negedge Clk) begin
        if (Rst_n && out_valid && out_ready)
            got_q.push_back({out_operand, out_root, err_bit});
        if (Rst_n && sq_start)
            start_q.push_back(cyc);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input bit expect_it);
        int n = 0;
        while (!in_ready && n < 500) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL push_ready data=%0d in_ready=%b want 1", d, in_ready);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        tick();
        last_push = cyc;
        in_valid = 1'b0;
        if (expect_it) exp_q.push_back({d, isqrt(d), 1'b0});
    endtask

    task automatic wait_results(input int n, input int bound);
        int k = 0;
        while (got_q.size() < n && k < bound) begin
            tick();
            k++;
        end
        total++;
        if (got_q.size() < n) begin
            bad++;
            $display("FAIL result_wait got=%0d want=%0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({in_ready, sq_A, sq_start, out_valid, out_operand, out_root,
             busy, err_timeout} !== {1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 4'd0,
             1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals rdy=%b A=%0d st=%b v=%b op=%0d rt=%0d bsy=%b err=%b",
                     in_ready, sq_A, sq_start, out_valid, out_operand,
                     out_root, busy, err_timeout);
        end
        total++;
        if (err_bit !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_err got=%b want 0", err_bit);
        end
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [12:0] e, g;
        lat = 4;
        start_q.delete();
        push(8'd81, 1'b1);
        wait_results(1, 200);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL single_result got=%h want=%h", g, e);
            end
        end
        repeat (3) tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_busy got=%b want 0", busy);
        end
        total++;
        if (start_q.size() != 1) begin
            bad++;
            $display("FAIL single_starts got=%0d want 1", start_q.size());
        end else begin
            total++;
            if (start_q[0] != last_push + 1) begin
                bad++;
                $display("FAIL single_start_cycle got=%0d want=%0d",
                         start_q[0], last_push + 1);
            end
        end
    endtask

    task automatic test_burst();
        logic [12:0] e, g;
        logic [7:0] ops [4] = '{8'd0, 8'd1, 8'd255, 8'd16};
        lat = 4;
        start_q.delete();
        foreach (ops[i]) push(ops[i], 1'b1);
        wait_results(4, 400);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL burst_result got=%h want=%h", g, e);
            end
        end
        total++;
        if (start_q.size() != 4) begin
            bad++;
            $display("FAIL burst_starts got=%0d want 4", start_q.size());
        end
        for (int i = 1; i < start_q.size(); i++) begin
            total++;
            if (start_q[i] - start_q[i-1] < lat + 4) begin
                bad++;
                $display("FAIL burst_spacing got=%0d want>=%0d",
                         start_q[i] - start_q[i-1], lat + 4);
            end
        end
    endtask

    task automatic test_full();
        logic [12:0] e, g;
        bit refused_ok = 1'b1;
        lat = 40;
        push(8'd10, 1'b1);
        for (int i = 0; i < DEPTH; i++) push(8'(20 + 30 * i), 1'b1);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_ready got=%b want 0", in_ready);
        end
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (5) begin
            tick();
            if (in_ready !== 1'b0) refused_ok = 1'b0;
        end
        in_valid = 1'b0;
        total++;
        if (!refused_ok) begin
            bad++;
            $display("FAIL full_refuse in_ready rose while full, want 0");
        end
        wait_results(DEPTH + 1, 800);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL full_result got=%h want=%h", g, e);
            end
        end
        repeat (60) tick();
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL full_extra got=%0d results want 0", got_q.size());
        end
        got_q.delete();
        lat = 4;
    endtask

    task automatic test_backpressure();
        logic [12:0] e, g;
        logic [11:0] snap;
        int ns, k;
        bit stable = 1'b1;
        lat = 4;
        out_ready = 1'b0;
        start_q.delete();
        push(8'd144, 1'b1);
        push(8'd100, 1'b1);
        k = 0;
        while (!out_valid && k < 200) begin
            tick();
            k++;
        end
        snap = {out_operand, out_root};
        ns = start_q.size();
        total++;
        if (snap !== {8'd144, 4'd12} || !out_valid) begin
            bad++;
            $display("FAIL bp_first got=%h v=%b want=%h", snap, out_valid,
                     {8'd144, 4'd12});
        end
        repeat (10) begin
            tick();
            if (!out_valid || {out_operand, out_root} !== snap) stable = 1'b0;
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL bp_stable outputs changed during stall, want %h", snap);
        end
        total++;
        if (start_q.size() != ns) begin
            bad++;
            $display("FAIL bp_nostart got=%0d want=%0d", start_q.size(), ns);
        end
        out_ready = 1'b1;
        wait_results(2, 200);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL bp_result got=%h want=%h", g, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [12:0] e, g;
        int k = 0;
        lat = 4;
        stall = 1'b1;
        push(8'd200, 1'b0);
        push(8'd49, 1'b1);
        while (!err_timeout && k < TIMEOUT + 40) begin
            tick();
            k++;
        end
        stall = 1'b0;
        total++;
        if (err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL tmo_flag got=%b want 1", err_timeout);
        end
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL tmo_noresult got=%0d want 0", got_q.size());
        end
        wait_results(1, 200);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL tmo_next got=%h want=%h", g, e);
            end
        end
        total++;
        if (err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL tmo_sticky got=%b want 1", err_timeout);
        end
    endtask

    task automatic test_mid_reset();
        logic [12:0] e, g;
        int k = 0;
        lat = 20;
        start_q.delete();
        push(8'd81, 1'b1);
        push(8'd64, 1'b1);
        push(8'd36, 1'b1);
        while (start_q.size() == 0 && k < 50) begin
            tick();
            k++;
        end
        repeat (5) tick();
        Rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, sq_A, sq_start, out_valid, out_operand, out_root,
             busy, err_timeout, err_bit} !== {1'b1, 8'd0, 1'b0, 1'b0, 8'd0,
             4'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midrst_vals rdy=%b A=%0d st=%b v=%b op=%0d rt=%0d bsy=%b err=%b",
                     in_ready, sq_A, sq_start, out_valid, out_operand,
                     out_root, busy, err_timeout);
        end
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        start_q.delete();
        repeat (30) tick();
        total++;
        if (start_q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_empty starts=%0d busy=%b want 0/0",
                     start_q.size(), busy);
        end
        lat = 4;
        wrong = 1'b1;
        push(8'd81, 1'b0);
        exp_q.push_back({8'd81, 4'd8, ERR_W});
        wait_results(1, 200);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL midrst_wrong_root got=%h want=%h", g, e);
            end
        end
        wrong = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_backpressure();
        test_timeout();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
